// File: rtl/uart_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_bridge_pkg                                              |
// | Description : Shared types, default depths and the FIFO count-width        |
// |               helper for the UART stream bridge.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_bridge_pkg;

   typedef logic [7:0] byte_t;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_TX_DEPTH = 16;
   localparam int DEF_RX_DEPTH = 16;

   // A count must represent 0..DEPTH inclusive, hence one bit above the
   // pointer width.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_fifo                                                    |
// | Description : Single-clock first-word-fall-through FIFO. DEPTH must be a   |
// |               power of two (>= 2) so pointers wrap naturally.              |
// | Ports       : clk, reset (async, active high)                              |
// |               wdata/we   - push side; push ignored when full               |
// |               rdata/re   - FWFT head and pop strobe; pop ignored if empty  |
// |               full/empty - decoded from the registered count               |
// |               count      - current occupancy                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync_fifo
   import uart_bridge_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int DEPTH  = DEF_TX_DEPTH,
   localparam int CNT_W  = count_width(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] wdata,
   input  logic              we,
   output logic              full,
   output logic [DATA_W-1:0] rdata,
   input  logic              re,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_push;
   logic              w_pop;

   assign full   = (r_count == CNT_W'(DEPTH));
   assign empty  = (r_count == '0);
   assign count  = r_count;
   assign w_push = we && !full;
   assign w_pop  = re && !empty;

   // Head is forced to zero while empty so the output is clean out of reset.
   assign rdata  = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: nothing is visible unless the count covers it.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wdata;
   end

endmodule
`default_nettype wire

// File: rtl/uart_stream_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_stream_bridge                                           |
// | Description : Byte buffer between the core's serial I/O and an AXI-stream  |
// |               UART. TX FIFO drains onto m_axis, RX FIFO fills from s_axis. |
// | Ports       : tx_wdata/tx_we/tx_full/tx_drop - core push side              |
// |               m_axis_*                       - to UART input stream        |
// |               s_axis_*                       - from UART output stream     |
// |               rx_rdata/rx_re/rx_empty        - core pop side (FWFT)        |
// |               rx_overrun/rx_overrun_clr      - sticky RX loss flag         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_stream_bridge
   import uart_bridge_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int TX_DEPTH = DEF_TX_DEPTH,
   parameter int RX_DEPTH = DEF_RX_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] tx_wdata,
   input  logic              tx_we,
   output logic              tx_full,
   output logic              tx_drop,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   output logic [DATA_W-1:0] rx_rdata,
   input  logic              rx_re,
   output logic              rx_empty,
   output logic              rx_overrun,
   input  logic              rx_overrun_clr
);

   localparam int TX_CNT_W = count_width(TX_DEPTH);
   localparam int RX_CNT_W = count_width(RX_DEPTH);

   logic                w_tx_empty;
   logic                w_rx_full;
   logic                w_rx_push;
   logic                w_rx_lost;
   logic [TX_CNT_W-1:0] w_tx_count_unused;
   logic [RX_CNT_W-1:0] w_rx_count_unused;
   logic                r_tx_drop;
   logic                r_rx_overrun;
   logic                r_s_tready;

   // A byte only transfers on a real handshake; tready is low for the first
   // edge after reset release, so nothing is captured there.
   assign w_rx_push = s_axis_tvalid && r_s_tready;
   // Full is the pre-edge value, so a same-cycle pop never rescues the byte.
   assign w_rx_lost = w_rx_push && w_rx_full;

   assign m_axis_tvalid = !w_tx_empty;
   assign tx_drop       = r_tx_drop;
   assign rx_overrun    = r_rx_overrun;
   assign s_axis_tready = r_s_tready;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (TX_DEPTH)
   ) u_tx_fifo (
      .clk    (clk),
      .reset  (reset),
      .wdata  (tx_wdata),
      .we     (tx_we),
      .full   (tx_full),
      .rdata  (m_axis_tdata),
      .re     (m_axis_tready),
      .empty  (w_tx_empty),
      .count  (w_tx_count_unused)
   );

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (RX_DEPTH)
   ) u_rx_fifo (
      .clk    (clk),
      .reset  (reset),
      .wdata  (s_axis_tdata),
      .we     (w_rx_push),
      .full   (w_rx_full),
      .rdata  (rx_rdata),
      .re     (rx_re),
      .empty  (rx_empty),
      .count  (w_rx_count_unused)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_drop    <= 1'b0;
         r_rx_overrun <= 1'b0;
         r_s_tready   <= 1'b0;
      end else begin
         // The UART is never back-pressured; overflow is handled by dropping.
         r_s_tready <= 1'b1;
         r_tx_drop  <= tx_we && tx_full;
         // A new loss wins over a clear arriving in the same cycle.
         if (w_rx_lost)
            r_rx_overrun <= 1'b1;
         else if (rx_overrun_clr)
            r_rx_overrun <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_stream_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_stream_bridge                                        |
// | Description : Self-checking bench for uart_stream_bridge: directed cases   |
// |               followed by randomized traffic with a mid-stream reset,      |
// |               compared against a queue-based reference model.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_stream_bridge;
   import uart_bridge_pkg::*;

   localparam int TXD = 16;
   localparam int RXD = 16;

   logic  clk = 1'b0;
   logic  reset;
   byte_t tx_wdata;
   logic  tx_we;
   logic  tx_full;
   logic  tx_drop;
   byte_t m_axis_tdata;
   logic  m_axis_tvalid;
   logic  m_axis_tready;
   byte_t s_axis_tdata;
   logic  s_axis_tvalid;
   logic  s_axis_tready;
   byte_t rx_rdata;
   logic  rx_re;
   logic  rx_empty;
   logic  rx_overrun;
   logic  rx_overrun_clr;

   always #5 clk = ~clk;

   uart_stream_bridge #(
      .DATA_W   (8),
      .TX_DEPTH (TXD),
      .RX_DEPTH (RXD)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .tx_wdata       (tx_wdata),
      .tx_we          (tx_we),
      .tx_full        (tx_full),
      .tx_drop        (tx_drop),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tready  (s_axis_tready),
      .rx_rdata       (rx_rdata),
      .rx_re          (rx_re),
      .rx_empty       (rx_empty),
      .rx_overrun     (rx_overrun),
      .rx_overrun_clr (rx_overrun_clr)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: byte queues plus the three flag bits.
   byte_t tx_q[$];
   byte_t rx_q[$];
   byte_t tx_seen[$];
   byte_t rx_seen[$];
   bit    drop_m;
   bit    ovr_m;
   bit    tready_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_clear();
      tx_q.delete();
      rx_q.delete();
      drop_m   = 1'b0;
      ovr_m    = 1'b0;
      tready_m = 1'b0;
   endtask

   task automatic compare_all();
      check("tx_full",   32'(tx_full),       32'(tx_q.size() == TXD));
      check("tx_drop",   32'(tx_drop),       32'(drop_m));
      check("tvalid",    32'(m_axis_tvalid), 32'(tx_q.size() != 0));
      check("s_tready",  32'(s_axis_tready), 32'(tready_m));
      check("rx_empty",  32'(rx_empty),      32'(rx_q.size() == 0));
      check("overrun",   32'(rx_overrun),    32'(ovr_m));
      if (tx_q.size() != 0) check("tdata", 32'(m_axis_tdata), 32'(tx_q[0]));
      if (rx_q.size() != 0) check("rdata", 32'(rx_rdata),     32'(rx_q[0]));
   endtask

   // Apply the current inputs to the model, advance one clock, compare.
   task automatic tick();
      bit t_pop, t_push, r_acc, r_pop;
      if (reset) begin
         model_clear();
      end else begin
         t_pop  = (tx_q.size() != 0) && m_axis_tready;
         t_push = tx_we && (tx_q.size() != TXD);
         drop_m = tx_we && (tx_q.size() == TXD);
         r_acc  = s_axis_tvalid && tready_m;
         r_pop  = rx_re && (rx_q.size() != 0);
         if (r_acc && rx_q.size() == RXD) ovr_m = 1'b1;
         else if (rx_overrun_clr)         ovr_m = 1'b0;
         if (t_pop) begin
            tx_seen.push_back(m_axis_tdata);
            void'(tx_q.pop_front());
         end
         if (t_push) tx_q.push_back(tx_wdata);
         if (r_pop) begin
            rx_seen.push_back(rx_rdata);
            void'(rx_q.pop_front());
         end
         if (r_acc && rx_q.size() + (r_pop ? 1 : 0) != RXD) rx_q.push_back(s_axis_tdata);
         tready_m = 1'b1;
      end
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      // Reset held with activity on both input sides.
      reset = 1'b1; tx_we = 1'b1; tx_wdata = 8'hAA; m_axis_tready = 1'b0;
      s_axis_tdata = 8'h77; s_axis_tvalid = 1'b1; rx_re = 1'b0; rx_overrun_clr = 1'b0;
      model_clear();
      #1;
      check("rst_tx_full", 32'(tx_full),       32'd0);
      check("rst_tx_drop", 32'(tx_drop),       32'd0);
      check("rst_tvalid",  32'(m_axis_tvalid), 32'd0);
      check("rst_tdata",   32'(m_axis_tdata),  32'd0);
      check("rst_tready",  32'(s_axis_tready), 32'd0);
      check("rst_rx_empty",32'(rx_empty),      32'd1);
      check("rst_rdata",   32'(rx_rdata),      32'd0);
      check("rst_overrun", 32'(rx_overrun),    32'd0);
      tick(); tick();
      tx_we = 1'b0; s_axis_tvalid = 1'b0; reset = 1'b0;
      #1;
      check("tready_at_release", 32'(s_axis_tready), 32'd0);
      tick();
      check("tready_first_edge", 32'(s_axis_tready), 32'd1);

      // Three pushes, then drain in order.
      tx_we = 1'b1;
      tx_wdata = 8'h41; tick();
      check("tvalid_after_first_push", 32'(m_axis_tvalid), 32'd1);
      check("tdata_first", 32'(m_axis_tdata), 32'h41);
      tx_wdata = 8'h42; tick();
      tx_wdata = 8'h43; tick();
      tx_we = 1'b0; m_axis_tready = 1'b1;
      tx_seen.delete();
      repeat (3) tick();
      check("abc_count", 32'(tx_seen.size()), 32'd3);
      for (int i = 0; i < 3 && i < tx_seen.size(); i++)
         check("abc_order", 32'(tx_seen[i]), 32'h41 + i);
      check("tvalid_after_drain", 32'(m_axis_tvalid), 32'd0);

      // Overfill TX with 17 bytes.
      m_axis_tready = 1'b0; tx_we = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tx_wdata = 8'(i);
         tick();
         if (i == 15) check("tx_full_after_16", 32'(tx_full), 32'd1);
         if (i == 16) check("tx_drop_on_17th", 32'(tx_drop), 32'd1);
      end
      tx_we = 1'b0; tick();
      check("tx_drop_single_pulse", 32'(tx_drop), 32'd0);
      m_axis_tready = 1'b1;
      tx_seen.delete();
      repeat (17) tick();
      check("fill_drain_count", 32'(tx_seen.size()), 32'd16);
      for (int i = 0; i < 16 && i < tx_seen.size(); i++)
         check("fill_drain_data", 32'(tx_seen[i]), 32'(i));

      // Full FIFO, push and pop in the same cycle: push rejected.
      m_axis_tready = 1'b0; tx_we = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tx_wdata = 8'(8'h20 + i);
         tick();
      end
      tx_wdata = 8'h55; m_axis_tready = 1'b1; tick();
      check("full_pushpop_drop", 32'(tx_drop), 32'd1);
      check("full_pushpop_notfull", 32'(tx_full), 32'd0);
      tx_wdata = 8'h66; m_axis_tready = 1'b0; tick();
      check("full_pushpop_count15", 32'(tx_full), 32'd1);
      tx_we = 1'b0; m_axis_tready = 1'b1;
      tx_seen.delete();
      repeat (16) tick();
      check("full_pushpop_drain", 32'(tx_seen.size()), 32'd16);
      if (tx_seen.size() == 16) begin
         check("full_pushpop_first", 32'(tx_seen[0]),  32'h21);
         check("full_pushpop_last",  32'(tx_seen[15]), 32'h66);
      end
      m_axis_tready = 1'b0;

      // RX overrun with 17 bytes, clear, and set-over-clear priority.
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         s_axis_tdata = 8'(8'h80 + i);
         tick();
      end
      check("rx_overrun_set", 32'(rx_overrun), 32'd1);
      s_axis_tvalid = 1'b0; rx_overrun_clr = 1'b1; tick();
      check("rx_overrun_clr", 32'(rx_overrun), 32'd0);
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'hEE; tick();
      check("rx_overrun_set_wins", 32'(rx_overrun), 32'd1);
      s_axis_tvalid = 1'b0; rx_overrun_clr = 1'b0; rx_re = 1'b1;
      rx_seen.delete();
      repeat (17) tick();
      check("rx_drain_count", 32'(rx_seen.size()), 32'd16);
      for (int i = 0; i < 16 && i < rx_seen.size(); i++)
         check("rx_drain_data", 32'(rx_seen[i]), 32'h80 + i);
      check("rx_overrun_sticky", 32'(rx_overrun), 32'd1);
      rx_re = 1'b0; rx_overrun_clr = 1'b1; tick();
      rx_overrun_clr = 1'b0;

      // Randomized traffic at both ends with an asynchronous reset mid-stream.
      for (int c = 0; c < 2000; c++) begin
         if (c == 1000) begin
            #3;
            reset = 1'b1;
            model_clear();
            #1;
            compare_all();
            check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
            check("midrst_rx_empty", 32'(rx_empty), 32'd1);
            tick(); tick();
            reset = 1'b0;
            #1;
            compare_all();
         end
         tx_we          = ($urandom % 10) < 6;
         tx_wdata       = 8'($urandom);
         m_axis_tready  = ($urandom % 10) < 5;
         s_axis_tvalid  = ($urandom % 10) < 5;
         s_axis_tdata   = 8'($urandom);
         rx_re          = ($urandom % 10) < 4;
         rx_overrun_clr = ($urandom % 16) == 0;
         tick();
      end

      // Drain both sides and confirm everything empties.
      tx_we = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1; rx_re = 1'b1;
      rx_overrun_clr = 1'b0;
      repeat (20) tick();
      check("final_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("final_rx_empty", 32'(rx_empty), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_stream_bridge.md
Name: uart_stream_bridge

Overview:
- Byte-stream buffer between the processor core's byte-level serial I/O and the AXI-stream UART.
- TX path: the core pushes bytes into a TX FIFO, which drains onto the UART input stream.
- RX path: bytes arriving on the UART output stream are captured into an RX FIFO, which the core pops.
- Everything runs on a single clock domain, the UART clock. No CDC inside this block.

Parameters:
- DATA_W, 8: byte width on all data ports.
- TX_DEPTH, 16: TX FIFO entries. Must be a power of two and ≥2.
- RX_DEPTH, 16: RX FIFO entries. Must be a power of two and ≥2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_wdata  in  DATA_W  byte to transmit.
- tx_we  in  1  push strobe; one byte per cycle while high.
- tx_full  out  1  TX FIFO full.
- tx_drop  out  1  one-cycle pulse: push rejected because the FIFO was full.
- m_axis_tdata  out  DATA_W  head of TX FIFO, to UART input_axis_tdata.
- m_axis_tvalid  out  1  TX FIFO non-empty.
- m_axis_tready  in  1  UART accepts byte.
- s_axis_tdata  in  DATA_W  received byte from UART output_axis_tdata.
- s_axis_tvalid  in  1  received byte valid.
- s_axis_tready  out  1  constant 1 after reset release.
- rx_rdata  out  DATA_W  head of RX FIFO (first-word-fall-through).
- rx_re  in  1  pop strobe.
- rx_empty  out  1  RX FIFO empty.
- rx_overrun  out  1  sticky: a byte was lost because the RX FIFO was full.
- rx_overrun_clr  in  1  clears rx_overrun.

Behaviour:
- Reset (asynchronous, reset=1) sets these outputs immediately:
  - both FIFOs empty, tx_full=0, tx_drop=0, m_axis_tvalid=0, rx_empty=1, rx_overrun=0, s_axis_tready=0.
  - tdata/rdata outputs are 0.
- Reset mid-operation discards all buffered bytes with no further handshakes. A byte already handed to the UART is not recalled.
- Each FIFO:
  - read pointer, write pointer and count are registered; count is clog2(DEPTH)+1 bits wide.
  - pointers wrap modulo DEPTH.
  - full = (count==DEPTH); empty = (count==0); both derived from registered count.
- TX push accepted when tx_we && !tx_full. The byte enters at wr_ptr and wr_ptr++.
- tx_we && tx_full:
  - byte discarded; tx_drop=1 for exactly that cycle +1 (registered pulse).
  - rejected even if the UART pops in the same cycle, because full is evaluated from the pre-edge count.
- TX pop occurs when m_axis_tvalid && m_axis_tready; rd_ptr++.
- m_axis_tdata is stable while m_axis_tvalid=1 and tready=0, per AXI-stream rules.
- TX latency: a push into an empty FIFO gives m_axis_tvalid=1 on the next cycle. There is no same-cycle bypass.
- Simultaneous TX push and pop with the FIFO neither full nor empty: count unchanged, both pointers advance.
- RX capture occurs when s_axis_tvalid=1 and the FIFO is not full.
- s_axis_tvalid=1 with the RX FIFO full:
  - byte dropped, rx_overrun set, FIFO contents untouched.
  - a simultaneous rx_re pop does not rescue it (pre-edge full).
- RX pop: rx_re && !rx_empty advances rd_ptr. rx_re while empty is ignored.
- rx_rdata is valid whenever rx_empty=0. It updates the cycle after a pop.
- rx_overrun:
  - set has priority over rx_overrun_clr in the same cycle.
  - otherwise rx_overrun_clr clears it on the next edge.
- s_axis_tready goes 1 on the first edge after reset deasserts and stays 1. Overflow is handled by dropping bytes, never by back-pressuring the UART.
- No other state machine exists; all control is counter/pointer based.

Decomposition:
- Shared package uart_bridge_pkg holds:
  - typedef byte_t (logic [7:0]);
  - localparams for default depths;
  - function clog2-based count width.
- One natural sub-module: sync_fifo, parameterised by DATA_W and DEPTH.
  - Ports: clk, reset, wdata, we, full, rdata, re, empty, count.
  - FWFT read; a push is ignored when full and a pop is ignored when empty.
- uart_stream_bridge instantiates sync_fifo twice and adds tx_drop, rx_overrun and tready logic.

Test Plan:
- Reset with tx_we=1, s_axis_tvalid=1 held → all outputs at reset values, rx_empty=1, s_axis_tready=0; one edge after release, s_axis_tready=1.
- Push 0x41,0x42,0x43 on consecutive cycles with m_axis_tready=0, then tready=1 → tvalid high from cycle after first push; bytes 0x41,0x42,0x43 delivered in order; tvalid=0 after third.
- Push 17 bytes 0x00..0x10 with tready=0 (TX_DEPTH=16) → tx_full=1 after 16th; 17th gives tx_drop pulse; draining yields exactly 0x00..0x0F.
- With the TX FIFO full, assert tx_we and tready together → pop occurs, push rejected, tx_drop=1, count=15.
- Deliver 17 RX bytes 0x80..0x90 without rx_re → rx_overrun=1, FIFO holds 0x80..0x8F; rx_overrun_clr → 0; a simultaneous new overrun and clr leaves rx_overrun=1.
- Randomised concurrent push/pop at both ends for 2000 cycles with reset asserted mid-stream at cycle 1000 → scoreboard order preserved; after reset, FIFOs empty with no spurious tvalid.
